// File: rtl/mseq_pkg.sv
// Shared constants and helpers for the M-sequence generator/checker pair.
// The register width is derived from the polynomial MSB index via log2().
package mseq_pkg;

    localparam logic [31:0] C_DEF_POLY = 32'h0001_6801;

    localparam logic [0:0] S_HUNT   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    function automatic int log2(input logic [31:0] i_v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if (i_v[i])
                r = i;
        return r;
    endfunction

endpackage

// File: rtl/mseq_checker_if.sv
// Stream/status bundle between an M-sequence source and the checker.
// master drives the bit stream, slave (the checker) returns status.
interface mseq_checker_if #(
    parameter int C_ERR_CNT_W = 16
);
    logic                   EN_CK_i;
    logic                   DAT_i;
    logic                   CLR_i;
    logic                   LOCK_o;
    logic                   ERR_o;
    logic [C_ERR_CNT_W-1:0] ERR_CNT_o;

    modport master (
        output EN_CK_i, DAT_i, CLR_i,
        input  LOCK_o, ERR_o, ERR_CNT_o
    );

    modport slave (
        input  EN_CK_i, DAT_i, CLR_i,
        output LOCK_o, ERR_o, ERR_CNT_o
    );
endinterface

// File: rtl/mseq_lock_mon.sv
// Lock monitor: fill/run/window counters and the HUNT/LOCKED machine.
// Lock is declared after C_LOCK_CNT qualified matches; lost on C_UNLOCK_ERR errors per window.
module mseq_lock_mon
    import mseq_pkg::*;
#(
    parameter int C_W          = 16,
    parameter int C_LOCK_CNT   = 32,
    parameter int C_WIN        = 64,
    parameter int C_UNLOCK_ERR = 8
) (
    input  logic CK_i,
    input  logic ARST_i,
    input  logic i_valid,
    input  logic i_qual,
    input  logic i_match,
    output logic o_lock,
    output logic o_err
);

    localparam int FW = $clog2(C_W + 1);
    localparam int RW = $clog2(C_LOCK_CNT + 1);
    localparam int NW = (C_WIN > 1) ? $clog2(C_WIN) : 1;
    localparam int EW = $clog2(C_UNLOCK_ERR + 1);

    logic [0:0]    r_state;
    logic [FW-1:0] r_fill;
    logic [RW-1:0] r_run;
    logic [NW-1:0] r_win;
    logic [EW-1:0] r_werr;
    logic          r_err;

    logic          w_full;
    logic          w_wrap;
    logic [RW-1:0] w_run_nxt;
    logic [EW-1:0] w_werr_base;
    logic [EW-1:0] w_werr_nxt;

    assign w_full      = (r_fill == FW'(C_W));
    assign w_wrap      = (r_win == NW'(C_WIN - 1));
    assign w_run_nxt   = (w_full && i_qual && i_match) ? r_run + RW'(1) : '0;
    // A mismatch on the wrap bit belongs to the new window
    assign w_werr_base = w_wrap ? '0 : r_werr;
    assign w_werr_nxt  = w_werr_base + EW'(!i_match);

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            r_state <= S_HUNT;
            r_fill  <= '0;
            r_run   <= '0;
            r_win   <= '0;
            r_werr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= i_valid && (r_state == S_LOCKED) && !i_match;
            if (i_valid) begin
                if (r_state == S_HUNT) begin
                    if (!w_full)
                        r_fill <= r_fill + FW'(1);
                    if (w_run_nxt == RW'(C_LOCK_CNT)) begin
                        r_state <= S_LOCKED;
                        r_run   <= '0;
                        r_win   <= '0;
                        r_werr  <= '0;
                    end else begin
                        r_run <= w_run_nxt;
                    end
                end else begin
                    r_win <= w_wrap ? '0 : r_win + NW'(1);
                    if (w_werr_nxt == EW'(C_UNLOCK_ERR)) begin
                        r_state <= S_HUNT;
                        r_fill  <= '0;
                        r_run   <= '0;
                        r_werr  <= '0;
                    end else begin
                        r_werr <= w_werr_nxt;
                    end
                end
            end
        end
    end

    assign o_lock = (r_state == S_LOCKED);
    assign o_err  = r_err;

endmodule

// File: rtl/mseq_checker.sv
// Receive-side M-sequence checker: self-synchronizing predictor in HUNT,
// flywheel predictor once locked, with a saturating bit-error counter.
module mseq_checker
    import mseq_pkg::*;
#(
    parameter logic [31:0] C_GF_COF     = C_DEF_POLY,
    parameter int          C_LOCK_CNT   = 32,
    parameter int          C_WIN        = 64,
    parameter int          C_UNLOCK_ERR = 8,
    parameter int          C_ERR_CNT_W  = 16
) (
    input logic           CK_i,
    input logic           ARST_i,
    mseq_checker_if.slave bus
);

    localparam int           W      = log2(C_GF_COF);
    localparam logic [W-1:0] C_TAPS = C_GF_COF[W:1];

    logic [W-1:0]           r_regs;
    logic [C_ERR_CNT_W-1:0] r_cnt;
    logic                   w_pred;
    logic                   w_match;
    logic                   w_lock;
    logic                   w_err;
    logic                   w_err_now;

    assign w_pred    = ^(r_regs & C_TAPS);
    assign w_match   = (bus.DAT_i == w_pred);
    assign w_err_now = bus.EN_CK_i && w_lock && !w_match;

    // Locked: feed back the prediction so line errors never enter the register
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i)
            r_regs <= '0;
        else if (bus.EN_CK_i)
            r_regs <= {r_regs[W-2:0], w_lock ? w_pred : bus.DAT_i};
    end

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i)
            r_cnt <= '0;
        else if (bus.CLR_i)
            r_cnt <= C_ERR_CNT_W'(w_err_now);
        else if (w_err_now && (r_cnt != '1))
            r_cnt <= r_cnt + C_ERR_CNT_W'(1);
    end

    mseq_lock_mon #(
        .C_W          (W),
        .C_LOCK_CNT   (C_LOCK_CNT),
        .C_WIN        (C_WIN),
        .C_UNLOCK_ERR (C_UNLOCK_ERR)
    ) u_mon (
        .CK_i    (CK_i),
        .ARST_i  (ARST_i),
        .i_valid (bus.EN_CK_i),
        .i_qual  (|r_regs),
        .i_match (w_match),
        .o_lock  (w_lock),
        .o_err   (w_err)
    );

    assign bus.LOCK_o    = w_lock;
    assign bus.ERR_o     = w_err;
    assign bus.ERR_CNT_o = r_cnt;

endmodule

// File: tb/tb_mseq_checker.sv
// Testbench for mseq_checker: generator-driven scenarios, default and 4-bit-counter instances.
// Expectations come from the stream construction (injected flips, lock latency rules).
module tb_mseq_checker;

    localparam logic [15:0] TAPS = 16'hB400;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [15:0] g;

    always #5 clk = ~clk;

    mseq_checker_if #(.C_ERR_CNT_W(16)) bus0 ();
    mseq_checker_if #(.C_ERR_CNT_W(4))  bus1 ();

    mseq_checker dut0 (
        .CK_i   (clk),
        .ARST_i (rst),
        .bus    (bus0)
    );

    mseq_checker #(
        .C_ERR_CNT_W  (4),
        .C_UNLOCK_ERR (64)
    ) dut1 (
        .CK_i   (clk),
        .ARST_i (rst),
        .bus    (bus1)
    );

    task automatic gen_bit(output logic o);
        o = ^(g & TAPS);
        g = {g[14:0], o};
    endtask

    task automatic step(input logic en, input logic dat, input logic clr);
        @(negedge clk);
        bus0.EN_CK_i = en; bus0.DAT_i = dat; bus0.CLR_i = clr;
        bus1.EN_CK_i = en; bus1.DAT_i = dat; bus1.CLR_i = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        @(negedge clk);
        rst = 1'b1;
        bus0.EN_CK_i = 0; bus0.DAT_i = 0; bus0.CLR_i = 0;
        bus1.EN_CK_i = 0; bus1.DAT_i = 0; bus1.CLR_i = 0;
        @(negedge clk);
        rst = 1'b0;
        g = 16'hFFFF;
    endtask

    task automatic clean_bits(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.EN_CK_i = 0; bus0.DAT_i = 0; bus0.CLR_i = 0;
        bus1.EN_CK_i = 0; bus1.DAT_i = 0; bus1.CLR_i = 0;
        @(posedge clk);
        #1;
        checks++;
        if (bus0.LOCK_o !== 1'b0) begin
            failures++; $display("FAIL reset_lock got=%b exp=0", bus0.LOCK_o);
        end
        checks++;
        if (bus0.ERR_o !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b exp=0", bus0.ERR_o);
        end
        checks++;
        if (bus0.ERR_CNT_o !== 16'd0) begin
            failures++; $display("FAIL reset_cnt got=%0d exp=0", bus0.ERR_CNT_o);
        end
        checks++;
        if (bus1.ERR_CNT_o !== 4'd0) begin
            failures++; $display("FAIL reset_cnt4 got=%0d exp=0", bus1.ERR_CNT_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clean_lock();
        logic b;
        int first = 0;
        int errs  = 0;
        restart();
        for (int n = 1; n <= 10000; n++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
            if (first == 0 && bus0.LOCK_o === 1'b1) first = n;
            if (bus0.ERR_o !== 1'b0) errs++;
        end
        checks++;
        if (first != 48) begin
            failures++; $display("FAIL clean_lock_bit got=%0d exp=48", first);
        end
        checks++;
        if (errs != 0) begin
            failures++; $display("FAIL clean_err_pulses got=%0d exp=0", errs);
        end
        checks++;
        if (bus0.ERR_CNT_o !== 16'd0) begin
            failures++; $display("FAIL clean_cnt got=%0d exp=0", bus0.ERR_CNT_o);
        end
    endtask

    task automatic test_single_flip();
        logic b;
        int pos    = $urandom_range(10, 150);
        int pulses = 0;
        int drops  = 0;
        int hit    = 0;
        for (int n = 0; n < 200; n++) begin
            gen_bit(b);
            step(1'b1, b ^ (n == pos), 1'b0);
            if (bus0.ERR_o === 1'b1) begin
                pulses++;
                if (n == pos) hit = 1;
            end
            if (bus0.LOCK_o !== 1'b1) drops++;
        end
        checks++;
        if (pulses != 1) begin
            failures++; $display("FAIL flip_pulses got=%0d exp=1", pulses);
        end
        checks++;
        if (hit != 1) begin
            failures++; $display("FAIL flip_pulse_pos got=%0d exp=1", hit);
        end
        checks++;
        if (drops != 0) begin
            failures++; $display("FAIL flip_lock_drops got=%0d exp=0", drops);
        end
        checks++;
        if (bus0.ERR_CNT_o !== 16'd1) begin
            failures++; $display("FAIL flip_cnt got=%0d exp=1", bus0.ERR_CNT_o);
        end
    endtask

    task automatic test_unlock_relock();
        logic        b;
        logic [63:0] mask = '0;
        int nset   = 0;
        int last   = -1;
        int fall   = -1;
        int relock = -1;
        int pulses = 0;
        while (nset < 8) begin
            int p = $urandom_range(0, 63);
            if (!mask[p]) begin
                mask[p] = 1'b1;
                nset++;
            end
        end
        for (int i = 0; i < 64; i++)
            if (mask[i]) last = i;
        restart();
        clean_bits(48);
        for (int n = 0; n < 300 && relock < 0; n++) begin
            gen_bit(b);
            step(1'b1, b ^ (n < 64 && mask[n]), 1'b0);
            if (bus0.ERR_o === 1'b1) pulses++;
            if (fall < 0 && bus0.LOCK_o !== 1'b1) fall = n;
            else if (fall >= 0 && bus0.LOCK_o === 1'b1) relock = n - fall;
        end
        checks++;
        if (fall != last) begin
            failures++; $display("FAIL unlock_bit got=%0d exp=%0d", fall, last);
        end
        checks++;
        if (relock != 48) begin
            failures++; $display("FAIL relock_bits got=%0d exp=48", relock);
        end
        checks++;
        if (pulses != 8) begin
            failures++; $display("FAIL unlock_pulses got=%0d exp=8", pulses);
        end
        checks++;
        if (bus0.ERR_CNT_o !== 16'd8) begin
            failures++; $display("FAIL unlock_cnt got=%0d exp=8", bus0.ERR_CNT_o);
        end
    endtask

    task automatic test_constant();
        int locks = 0;
        int errs  = 0;
        restart();
        for (int n = 0; n < 1000; n++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus0.LOCK_o !== 1'b0) locks++;
        end
        checks++;
        if (locks != 0) begin
            failures++; $display("FAIL zeros_lock got=%0d exp=0", locks);
        end
        restart();
        locks = 0;
        for (int n = 0; n < 1000; n++) begin
            step(1'b1, 1'b1, 1'b0);
            if (bus0.LOCK_o !== 1'b0) locks++;
            if (bus0.ERR_o !== 1'b0) errs++;
        end
        checks++;
        if (locks != 0) begin
            failures++; $display("FAIL ones_lock got=%0d exp=0", locks);
        end
        checks++;
        if (errs != 0 || bus0.ERR_CNT_o !== 16'd0) begin
            failures++;
            $display("FAIL ones_err got=%0d/%0d exp=0/0", errs, bus0.ERR_CNT_o);
        end
    endtask

    task automatic test_gaps();
        logic b;
        logic en;
        int valid = 0;
        int first = 0;
        int errs  = 0;
        restart();
        for (int n = 0; n < 600; n++) begin
            en = 1'($urandom_range(0, 1));
            if (en) begin
                gen_bit(b);
                valid++;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            step(en, b, 1'b0);
            if (first == 0 && bus0.LOCK_o === 1'b1) first = valid;
            if (bus0.ERR_o !== 1'b0) errs++;
        end
        checks++;
        if (first != 48) begin
            failures++; $display("FAIL gaps_lock_bit got=%0d exp=48", first);
        end
        checks++;
        if (errs != 0 || bus0.ERR_CNT_o !== 16'd0) begin
            failures++;
            $display("FAIL gaps_err got=%0d/%0d exp=0/0", errs, bus0.ERR_CNT_o);
        end
    endtask

    task automatic test_saturate();
        logic b;
        int pulses = 0;
        int drops  = 0;
        restart();
        clean_bits(48);
        for (int e = 0; e < 20; e++) begin
            int gap = $urandom_range(4, 12);
            for (int i = 0; i < gap; i++) begin
                gen_bit(b);
                step(1'b1, b, 1'b0);
                if (bus1.LOCK_o !== 1'b1) drops++;
            end
            gen_bit(b);
            step(1'b1, ~b, 1'b0);
            if (bus1.ERR_o === 1'b1) pulses++;
            if (bus1.LOCK_o !== 1'b1) drops++;
        end
        checks++;
        if (bus1.ERR_CNT_o !== 4'd15) begin
            failures++; $display("FAIL sat_cnt got=%0d exp=15", bus1.ERR_CNT_o);
        end
        checks++;
        if (pulses != 20 || drops != 0) begin
            failures++;
            $display("FAIL sat_pulses_drops got=%0d/%0d exp=20/0", pulses, drops);
        end
        gen_bit(b);
        step(1'b1, b, 1'b1);
        checks++;
        if (bus1.ERR_CNT_o !== 4'd0) begin
            failures++; $display("FAIL sat_clr got=%0d exp=0", bus1.ERR_CNT_o);
        end
        gen_bit(b);
        step(1'b1, ~b, 1'b1);
        checks++;
        if (bus1.ERR_CNT_o !== 4'd1) begin
            failures++; $display("FAIL clr_with_err got=%0d exp=1", bus1.ERR_CNT_o);
        end
        gen_bit(b);
        step(1'b1, ~b, 1'b0);
        checks++;
        if (bus1.ERR_o !== 1'b1 || bus1.ERR_CNT_o !== 4'd2) begin
            failures++;
            $display("FAIL pre_rst_err got=%b/%0d exp=1/2", bus1.ERR_o, bus1.ERR_CNT_o);
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        checks++;
        if (bus1.LOCK_o !== 1'b0 || bus1.ERR_o !== 1'b0 || bus1.ERR_CNT_o !== 4'd0) begin
            failures++;
            $display("FAIL async_rst got=%b/%b/%0d exp=0/0/0",
                     bus1.LOCK_o, bus1.ERR_o, bus1.ERR_CNT_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus1.LOCK_o !== 1'b0 || bus1.ERR_CNT_o !== 4'd0) begin
            failures++;
            $display("FAIL rst_hold got=%b/%0d exp=0/0", bus1.LOCK_o, bus1.ERR_CNT_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        g = 16'hFFFF;
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_unlock_relock();
        test_constant();
        test_gaps();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mseq_checker.md
# mseq_checker

Receive-side M-sequence checker that consumes the serial bit stream produced by the team's Fibonacci LFSR generator, using the same feedback polynomial. It self-synchronizes a local copy of the generator's shift register and declares lock after a run of correct predictions. Once locked, it free-runs as a flywheel and counts bit errors. It sits directly downstream of the generator, either on a loopback or after the link under test.

## Interface
- C_GF_COF, 17'b1_0110_1000_0000_0001: generator polynomial. W = bit index of MSB (16 by default) = register width. Taps = C_GF_COF[W:1].
- C_LOCK_CNT, 32: consecutive correct predictions required to lock (≥1).
- C_WIN, 64: loss-of-lock observation window, in valid bits.
- C_UNLOCK_ERR, 8: errors within one window that force loss of lock (1..C_WIN).
- C_ERR_CNT_W, 16: error counter width.
- CK_i  in  1  clock; all logic on rising edge.
- ARST_i  in  1  asynchronous, active-high reset.
- EN_CK_i  in  1  DAT_i valid strobe. When low, all state holds.
- DAT_i  in  1  received M-sequence bit.
- CLR_i  in  1  synchronous clear of ERR_CNT_o. Does not affect lock.
- LOCK_o  out  1  registered lock status.
- ERR_o  out  1  registered one-cycle error pulse.
- ERR_CNT_o  out  C_ERR_CNT_W  saturating error count since reset or CLR_i.

## Operation
- Core: REGS[W-1:0], newest bit at LSB. pred = ^(REGS & taps). On a valid bit, match = (DAT_i == pred).
- States: HUNT (reset state) and LOCKED.
- HUNT, per valid bit:
  - REGS <= {REGS[W-2:0], DAT_i}, i.e. self-synchronizing.
  - fill counter saturates at W.
  - Counting is qualified only when fill == W and REGS != 0. When qualified, run <= match ? run+1 : 0. Unqualified bits force run = 0.
  - When run reaches C_LOCK_CNT, go to LOCKED. On entry, win, werr and run are cleared.
- LOCKED, per valid bit:
  - REGS <= {REGS[W-2:0], pred}. Flywheel: errors never enter REGS, so there is no error multiplication.
  - On mismatch: ERR_o = 1, ERR_CNT_o increments (saturating at all-ones), werr increments.
  - win counts 0..C_WIN-1, then wraps. On wrap, werr is cleared. A mismatch on the wrap bit counts into the new window.
  - When werr reaches C_UNLOCK_ERR, go to HUNT immediately. On entry, fill, run and werr are cleared. REGS is kept.
- Boundary rules:
  - All-zero input never locks.
  - CLR_i together with an error sets ERR_CNT_o to 1.
  - CLR_i at saturation clears normally.
  - EN_CK_i low: no counter, state or REGS change, and ERR_o = 0.
  - Asserting ARST_i at any point, including mid-lock, restores reset values asynchronously.

## Timing
- Reset values:
  - LOCK_o = 0, ERR_o = 0, ERR_CNT_o = 0, REGS = 0, state = HUNT.
  - All internal counters = 0.
- ERR_o, ERR_CNT_o and LOCK_o update on the edge that samples the valid bit. They are visible the following cycle, so latency is 1 cycle from the sample.
- Lock time from reset with a clean stream: W + C_LOCK_CNT valid bits (48 by default). LOCK_o rises on the edge sampling bit 48.
- The bit that triggers loss of lock is counted as an error. LOCK_o falls on that same edge.
- No throughput limit: EN_CK_i may be high every cycle.

## Structure
- Shared package mseq_pkg:
  - log2 function, used for W derivation by both generator and checker.
  - default polynomial constant.
  - state encoding constants HUNT/LOCKED.
- One sub-module, mseq_lock_mon: fill, run, win and werr counters plus the HUNT/LOCKED state machine. Inputs are valid, qualify, match. Outputs are lock and error strobe.
- The top level holds REGS, the predictor and the error counter.

## Test plan
- Clean generator stream (default polynomial, seed all-ones), EN_CK_i = 1 → LOCK_o rises after exactly 48 bits; ERR_CNT_o stays 0 over 10,000 bits.
- Locked, flip a single bit → one ERR_o pulse, ERR_CNT_o = 1, LOCK_o stays 1, no further errors (flywheel proven).
- Locked, flip 8 bits within 64 → LOCK_o falls on the 8th error. Clean stream after that relocks after 48 bits. ERR_CNT_o = 8.
- Constant 0 input for 1,000 bits → LOCK_o never asserts. Constant 1 input → errors in HUNT are not counted; ERR_CNT_o = 0.
- Generator with random EN_CK_i gaps (50% duty) → lock after 48 valid bits; no errors.
- C_ERR_CNT_W = 4, C_UNLOCK_ERR = C_WIN, 20 errors spread so lock is held → ERR_CNT_o saturates at 15. CLR_i together with an error → 1. ARST_i pulse mid-lock → all outputs 0 on the next cycle.
